// File: rtl/sar_pkg.sv
// Shared types and constants for the SAR conversion controller.
package sar_pkg;

    localparam int unsigned NBIT_DEF = 10;
    localparam int unsigned AVG_LOG2 = 2;
    localparam int unsigned CNT_W    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAMPLE,
        ST_STROBE,
        ST_DECIDE,
        ST_DONE
    } sar_state_e;

    // Midscale trial code: only the MSB of an nbit-wide code set.
    function automatic logic [31:0] midscale(input int unsigned nbit);
        return 32'(1) << (nbit - 1);
    endfunction

endpackage

// File: rtl/sar_avg.sv
// Four-frame averaging of SAR results; only compiled when SAR_AVG_EN is defined.
`ifdef SAR_AVG_EN
module sar_avg
    import sar_pkg::*;
#(
    parameter int unsigned NBIT = NBIT_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            add_i,
    input  logic            clr_i,
    input  logic [NBIT-1:0] code_i,
    output logic            valid_c,
    output logic [NBIT-1:0] avg_c
);

    localparam int unsigned ACC_W = NBIT + AVG_LOG2;

    logic [ACC_W-1:0]    acc_q;
    logic [AVG_LOG2-1:0] n_q;
    logic [ACC_W-1:0]    sum_c;
    logic [ACC_W-1:0]    rounded_c;

    // Four full-scale codes plus the half-LSB rounding term still fit in ACC_W.
    assign sum_c     = acc_q + ACC_W'(code_i);
    assign rounded_c = sum_c + ACC_W'(1 << (AVG_LOG2 - 1));
    assign valid_c   = add_i && (n_q == '1);
    assign avg_c     = NBIT'(rounded_c >> AVG_LOG2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            n_q   <= '0;
        end else if (clr_i || valid_c) begin
            acc_q <= '0;
            n_q   <= '0;
        end else if (add_i) begin
            acc_q <= sum_c;
            n_q   <= n_q + AVG_LOG2'(1);
        end
    end

endmodule
`endif

// File: rtl/sar_ctrl.sv
// SAR ADC controller: sampling phase, binary search on the CDAC, result delivery.
// Define SAR_AVG_EN to deliver the rounded average of every four frames instead.
module sar_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned NBIT    = NBIT_DEF,
    parameter int unsigned SMP_CYC = 3
) (
    input  logic            CK,
    input  logic            RSTN,
    input  logic            CONV_EN,
    input  logic            CMP_OUT,
    output logic            SMP,
    output logic            CMP_EN,
    output logic [NBIT-1:0] DAC,
    output logic [NBIT-1:0] DOUT,
    output logic            DVALID,
    output logic            BUSY
);

    localparam int unsigned KW = $clog2(NBIT);

    sar_state_e      state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NBIT-1:0] dac_q, dac_d;
    logic [NBIT-1:0] dout_q, dout_d;
    logic            smp_q, smp_d;
    logic            cmp_en_q, cmp_en_d;
    logic            dvalid_q, dvalid_d;
    logic            busy_q, busy_d;
    logic            frame_done_c;
    logic            idle_entry_c;

    assign frame_done_c = (state_q == ST_DECIDE) && (state_d == ST_DONE);
    assign idle_entry_c = (state_q != ST_IDLE) && (state_d == ST_IDLE);

`ifdef SAR_AVG_EN
    logic            avg_valid_c;
    logic [NBIT-1:0] avg_c;

    sar_avg #(
        .NBIT (NBIT)
    ) u_avg (
        .clk     (CK),
        .rst_n   (RSTN),
        .add_i   (frame_done_c),
        .clr_i   (idle_entry_c),
        .code_i  (dac_d),
        .valid_c (avg_valid_c),
        .avg_c   (avg_c)
    );
`endif

    // Next state, search datapath and next values of the registered outputs.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        dac_d    = dac_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (CONV_EN) state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (cnt_q == CNT_W'(SMP_CYC - 1)) state_d = ST_STROBE;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            ST_STROBE: begin
                state_d = ST_DECIDE;
            end
            ST_DECIDE: begin
                dac_d[k_q] = CMP_OUT;
                if (k_q != '0) begin
                    dac_d[k_q - KW'(1)] = 1'b1;
                    k_d                 = k_q - KW'(1);
                    state_d             = ST_STROBE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = CONV_EN ? ST_SAMPLE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if ((state_d == ST_SAMPLE) && (state_q != ST_SAMPLE)) begin
            dac_d = NBIT'(midscale(NBIT));
            k_d   = KW'(NBIT - 1);
            cnt_d = '0;
        end

`ifdef SAR_AVG_EN
        if (avg_valid_c) begin
            dvalid_d = 1'b1;
            dout_d   = avg_c;
        end
`else
        if (frame_done_c) begin
            dvalid_d = 1'b1;
            dout_d   = dac_d;
        end
`endif

        smp_d    = (state_d == ST_SAMPLE);
        cmp_en_d = (state_d == ST_STROBE);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge CK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            k_q      <= KW'(NBIT - 1);
            cnt_q    <= '0;
            dac_q    <= '0;
            dout_q   <= '0;
            smp_q    <= 1'b0;
            cmp_en_q <= 1'b0;
            dvalid_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            cnt_q    <= cnt_d;
            dac_q    <= dac_d;
            dout_q   <= dout_d;
            smp_q    <= smp_d;
            cmp_en_q <= cmp_en_d;
            dvalid_q <= dvalid_d;
            busy_q   <= busy_d;
        end
    end

    assign SMP    = smp_q;
    assign CMP_EN = cmp_en_q;
    assign DAC    = dac_q;
    assign DOUT   = dout_q;
    assign DVALID = dvalid_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_sar_ctrl.sv
// Randomized self-checking bench for sar_ctrl with an ideal-comparator VIN model.
module tb_sar_ctrl;

    localparam int unsigned N = 10;
    parameter  int unsigned TB_SMP_CYC = 3;
    localparam int unsigned S = TB_SMP_CYC;
    localparam int unsigned L = S + 2 * N + 1;

    logic         CK;
    logic         RSTN;
    logic         CONV_EN;
    logic         CMP_OUT;
    logic         SMP;
    logic         CMP_EN;
    logic [N-1:0] DAC;
    logic [N-1:0] DOUT;
    logic         DVALID;
    logic         BUSY;

    logic [N-1:0] vin;
    logic         in_decide;
    logic         garbage;

    int unsigned  n_tests = 0;
    int unsigned  n_fail  = 0;
    int unsigned  avg_sum = 0;
    int unsigned  avg_n   = 0;
    logic [N-1:0] exp_dout = '0;

    sar_ctrl #(
        .NBIT    (N),
        .SMP_CYC (TB_SMP_CYC)
    ) dut (
        .CK      (CK),
        .RSTN    (RSTN),
        .CONV_EN (CONV_EN),
        .CMP_OUT (CMP_OUT),
        .SMP     (SMP),
        .CMP_EN  (CMP_EN),
        .DAC     (DAC),
        .DOUT    (DOUT),
        .DVALID  (DVALID),
        .BUSY    (BUSY)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // The cycle after a strobe is the decision cycle; elsewhere the comparator output is noise.
    always @(posedge CK or negedge RSTN) begin
        if (!RSTN) in_decide <= 1'b0;
        else       in_decide <= CMP_EN;
    end
    always @(negedge CK) garbage <= 1'($urandom);
    assign CMP_OUT = in_decide ? (vin >= DAC) : garbage;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Trial code presented for bit b: decided upper bits of VIN, bit b set, lower bits clear.
    function automatic logic [N-1:0] trial(input logic [N-1:0] v, input int unsigned b);
        int unsigned x;
        x = 32'(v);
        return N'(((x >> (b + 1)) << (b + 1)) | (32'(1) << b));
    endfunction

    // Result expected at the end of a frame whose converged code is `code`.
    task automatic model_frame(input logic [N-1:0] code, output logic ev, output logic [N-1:0] ed);
`ifdef SAR_AVG_EN
        avg_sum += 32'(code);
        avg_n++;
        if (avg_n == 4) begin
            ev       = 1'b1;
            exp_dout = N'((avg_sum + 2) / 4);
            avg_sum  = 0;
            avg_n    = 0;
        end else begin
            ev = 1'b0;
        end
`else
        ev       = 1'b1;
        exp_dout = code;
`endif
        ed = exp_dout;
    endtask

    task automatic model_idle();
        avg_sum = 0;
        avg_n   = 0;
    endtask

    // Walk one frame at negedges; abort_at >= 0 asserts RSTN at that frame offset.
    task automatic run_frame(input logic [N-1:0] v, input int abort_at);
        int e_smp, e_cmp, e_trial, e_ovl, e_busy, e_dv;
        logic         ev;
        logic [N-1:0] ed;
        logic         exp_smp, exp_cmp, exp_dv;
        e_smp = 0; e_cmp = 0; e_trial = 0; e_ovl = 0; e_busy = 0; e_dv = 0;
        ev = 1'b0; ed = exp_dout;
        vin = v;
        for (int i = 0; i < 4 && SMP !== 1'b1; i++) @(negedge CK);
        check("frame_start_smp", 32'(SMP), 32'(1));
        for (int o = 0; o < int'(L); o++) begin
            if (o == abort_at) begin
                RSTN = 1'b0;
                #1;
                check("arst_outputs", {SMP, CMP_EN, DAC, DOUT, DVALID, BUSY}, 32'(0));
                exp_dout = '0;
                model_idle();
                @(negedge CK);
                @(negedge CK);
                RSTN = 1'b1;
                for (int j = 0; j < 3; j++) begin
                    @(negedge CK);
                    if (DVALID !== 1'b0 || BUSY !== 1'b0) e_dv++;
                end
                check("post_rst_quiet", 32'(e_dv), 32'(0));
                check("post_rst_dout", 32'(DOUT), 32'(0));
                return;
            end
            if (o == int'(L) - 1) model_frame(v, ev, ed);
            exp_smp = (o < int'(S));
            exp_cmp = (o >= int'(S)) && (o < int'(S + 2 * N)) && (((o - int'(S)) % 2) == 0);
            exp_dv  = (o == int'(L) - 1) ? ev : 1'b0;
            if (SMP !== exp_smp) e_smp++;
            if (CMP_EN !== exp_cmp) e_cmp++;
            if (exp_cmp && DAC !== trial(v, N - 1 - (o - S) / 2)) e_trial++;
            if (SMP && CMP_EN) e_ovl++;
            if (BUSY !== 1'b1) e_busy++;
            if (DVALID !== exp_dv) e_dv++;
            if (o == int'(L) - 1) begin
                check("done_dac", 32'(DAC), 32'(v));
                check("done_dout", 32'(DOUT), 32'(ed));
            end
            @(negedge CK);
        end
        check("smp_shape", 32'(e_smp), 32'(0));
        check("cmp_en_shape", 32'(e_cmp), 32'(0));
        check("dac_trials", 32'(e_trial), 32'(0));
        check("smp_cmp_overlap", 32'(e_ovl), 32'(0));
        check("busy_in_frame", 32'(e_busy), 32'(0));
        check("dvalid_timing", 32'(e_dv), 32'(0));
    endtask

    task automatic pulse_conv();
        CONV_EN = 1'b1;
        @(negedge CK);
        CONV_EN = 1'b0;
    endtask

    task automatic check_idle_after(input logic [N-1:0] v);
        check("dvalid_single", 32'(DVALID), 32'(0));
        @(negedge CK);
        check("idle_busy", 32'(BUSY), 32'(0));
        check("idle_dac_hold", 32'(DAC), 32'(v));
        model_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] v;
        RSTN    = 1'b0;
        CONV_EN = 1'b0;
        vin     = '0;
        repeat (3) @(negedge CK);
        check("rst_smp", 32'(SMP), 32'(0));
        check("rst_cmp_en", 32'(CMP_EN), 32'(0));
        check("rst_dac", 32'(DAC), 32'(0));
        check("rst_dout", 32'(DOUT), 32'(0));
        check("rst_dvalid", 32'(DVALID), 32'(0));
        check("rst_busy", 32'(BUSY), 32'(0));
        RSTN = 1'b1;
        @(negedge CK);
        @(negedge CK);
        check("idle_no_start", 32'(BUSY), 32'(0));

        pulse_conv();
        run_frame(10'h2A5, -1);
        check_idle_after(10'h2A5);

        pulse_conv();
        run_frame(10'h3FF, -1);
        check_idle_after(10'h3FF);
        pulse_conv();
        run_frame(10'h000, -1);
        check_idle_after(10'h000);

        for (int t = 0; t < 5; t++) begin
            v = N'($urandom_range(0, 1023));
            pulse_conv();
            run_frame(v, -1);
            check_idle_after(v);
        end

        // Back-to-back frames; CONV_EN drops early in the third, which must still complete.
        CONV_EN = 1'b1;
        @(negedge CK);
        run_frame(N'($urandom_range(0, 1023)), -1);
        run_frame(N'($urandom_range(0, 1023)), -1);
        CONV_EN = 1'b0;
        v = N'($urandom_range(0, 1023));
        run_frame(v, -1);
        check_idle_after(v);

        pulse_conv();
        run_frame(N'($urandom_range(0, 1023)), int'(S) + 9);
        v = N'($urandom_range(0, 1023));
        pulse_conv();
        run_frame(v, -1);
        check_idle_after(v);

        CONV_EN = 1'b1;
        @(negedge CK);
        run_frame(10'h100, -1);
        run_frame(10'h101, -1);
        run_frame(10'h101, -1);
        CONV_EN = 1'b0;
        run_frame(10'h101, -1);
        check_idle_after(10'h101);
        check("final_dout", 32'(DOUT), 32'(exp_dout));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
